// File: rtl/spdif_i2s_tx.sv
// Pairs S/PDIF left/right sample strobes into frames, buffers them in a FIFO and replays them as a Philips I2S master stream.
// Define SPDIF_I2S_MUTE_ON_UNDERRUN_EN to play silence on underrun instead of repeating the last pair.
module spdif_i2s_tx #(
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          iClk,
    input  logic                          rst_i,
    input  logic                          iDatavalidL,
    input  logic                          iDatavalidR,
    input  logic [23:0]                   iDataL,
    input  logic [23:0]                   iDataR,
    output logic                          oBclk,
    output logic                          oLrck,
    output logic                          oSdata,
    output logic                          oUnderrun,
    output logic                          oOverrun,
    output logic [$clog2(FIFO_DEPTH):0]   oLevel
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned SW = 24;
    localparam int unsigned PW = 2 * SW;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [5:0]    BIT_LAST = 6'd63;

    logic [DW-1:0] divcnt_q, divcnt_d;
    logic          bclk_q, bclk_d;
    logic [5:0]    bitcnt_q, bitcnt_d;
    logic          lrck_q, lrck_d;
    logic          sdata_q, sdata_d;
    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;
    logic          have_l_q, have_l_d;
    logic [SW-1:0] stage_l_q, stage_l_d;
    logic [PW-1:0] shadow_q, shadow_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] mem_d [FIFO_DEPTH];

    logic          tc_c, fall_c, frame_start_c;
    logic          push_c, pop_c, wr_c, empty_c, full_c;
    logic [PW-1:0] push_data_c;
    logic [SW-1:0] slot_c;
    logic [31:0]   word_c;

    always_comb begin
        divcnt_d    = divcnt_q;
        bclk_d      = bclk_q;
        bitcnt_d    = bitcnt_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        underrun_d  = 1'b0;
        overrun_d   = 1'b0;
        have_l_d    = have_l_q;
        stage_l_d   = stage_l_q;
        shadow_d    = shadow_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        mem_d       = mem_q;
        push_c      = 1'b0;
        push_data_c = {stage_l_q, iDataR};
        slot_c      = '0;
        word_c      = '0;

        // BCLK divider; a fall event advances the bit position within the 64-bit frame
        tc_c          = (divcnt_q == DIV_LAST);
        fall_c        = tc_c && bclk_q;
        frame_start_c = fall_c && (bitcnt_q == BIT_LAST);
        if (tc_c) begin
            divcnt_d = '0;
            bclk_d   = ~bclk_q;
        end else begin
            divcnt_d = divcnt_q + DW'(1);
        end
        if (fall_c) begin
            bitcnt_d = bitcnt_q + 6'd1;
        end

        // Staging an L in the same cycle lets a coincident R complete the pair immediately
        if (iDatavalidL) begin
            stage_l_d = iDataL;
            have_l_d  = 1'b1;
        end
        if (iDatavalidR && have_l_d) begin
            push_c      = 1'b1;
            push_data_c = {stage_l_d, iDataR};
            have_l_d    = 1'b0;
        end

        // A pop on a full FIFO frees the slot for a coincident push
        empty_c   = (level_q == '0);
        full_c    = (level_q == LVL_FULL);
        pop_c     = frame_start_c && !empty_c;
        wr_c      = push_c && (!full_c || pop_c);
        overrun_d = push_c && full_c && !pop_c;
        if (wr_c) begin
            mem_d[wptr_q] = push_data_c;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + AW'(1);
        end
        level_d = level_q + LW'(wr_c) - LW'(pop_c);

        if (frame_start_c) begin
            if (!empty_c) begin
                shadow_d = mem_q[rptr_q];
            end else begin
                underrun_d = 1'b1;
`ifdef SPDIF_I2S_MUTE_ON_UNDERRUN_EN
                shadow_d = '0;
`else
                shadow_d = shadow_q;
`endif
            end
        end

        // One-bit I2S delay: the old bit position selects the slot and bit being shifted out
        if (fall_c) begin
            lrck_d  = bitcnt_d[5];
            slot_c  = bitcnt_q[5] ? shadow_d[SW-1:0] : shadow_d[PW-1:SW];
            word_c  = {slot_c, 8'h00};
            sdata_d = word_c[5'd31 - bitcnt_q[4:0]];
        end
    end

    always_ff @(posedge iClk) begin
        if (rst_i) begin
            divcnt_q   <= '0;
            bclk_q     <= 1'b0;
            bitcnt_q   <= BIT_LAST;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            have_l_q   <= 1'b0;
            stage_l_q  <= '0;
            shadow_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
        end else begin
            divcnt_q   <= divcnt_d;
            bclk_q     <= bclk_d;
            bitcnt_q   <= bitcnt_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            have_l_q   <= have_l_d;
            stage_l_q  <= stage_l_d;
            shadow_q   <= shadow_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level
    always_ff @(posedge iClk) begin
        mem_q <= mem_d;
    end

    assign oBclk     = bclk_q;
    assign oLrck     = lrck_q;
    assign oSdata    = sdata_q;
    assign oUnderrun = underrun_q;
    assign oOverrun  = overrun_q;
    assign oLevel    = level_q;

endmodule
